// File: rtl/spi_reg_ctrl_pkg.sv
// Shared definitions for the SPI register-access controller: FSM encoding,
// command byte layout, default special addresses and address sequencing.
package spi_reg_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_e;

  // Command byte: bit 7 selects write (1) or read (0), bits 6:0 the address.
  localparam int RW_BIT   = 7;
  localparam int ADDR_MSB = 6;

  localparam logic [6:0] STATUS_ADDR_DEF = 7'h7F;
  localparam logic [7:0] BAD_BYTE_DEF    = 8'hEE;

  // Burst address step: the status address is sticky, the last register
  // wraps back to register 0, anything else simply counts up.
  function automatic logic [6:0] addr_advance(input logic [6:0] addr,
                                              input logic [6:0] last_reg,
                                              input logic [6:0] status_addr);
    if (addr == status_addr) begin
      return addr;
    end else if (addr == last_reg) begin
      return 7'd0;
    end else begin
      return addr + 7'd1;
    end
  endfunction

endpackage

// File: rtl/spi_reg_bank.sv
// NUM_REGS x 8-bit register bank with one write port, a combinational read
// mux and the whole bank exposed flat for board-level logic.
module spi_reg_bank #(
  parameter int NUM_REGS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [6:0]            waddr_i,
  input  logic [7:0]            wdata_i,
  input  logic [6:0]            raddr_i,
  output logic [7:0]            rdata_o,
  output logic [8*NUM_REGS-1:0] regs_o
);

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [7:0] reg_q;

      // Register gi loads only when its own address is written.
      always_ff @(posedge clk) begin
        if (!rst) begin
          reg_q <= 8'h00;
        end else if (we_i && (waddr_i == 7'(gi))) begin
          reg_q <= wdata_i;
        end
      end

      assign regs_o[8*gi +: 8] = reg_q;
    end
  endgenerate

  // Read mux; addresses outside the bank read as zero (caller filters them).
  always_comb begin
    rdata_o = 8'h00;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (raddr_i == 7'(k)) begin
        rdata_o = regs_o[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/spi_reg_ctrl.sv
// Command controller on top of an SPI slave byte datapath: first byte of a
// frame is a read/write command with address, later bytes are burst data.
module spi_reg_ctrl
  import spi_reg_ctrl_pkg::*;
#(
  parameter int         NUM_REGS    = 4,
  parameter logic [6:0] STATUS_ADDR = STATUS_ADDR_DEF,
  parameter logic [7:0] BAD_BYTE    = BAD_BYTE_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ss,
  input  logic                  rx_done,
  input  logic [7:0]            rx_data,
  output logic [7:0]            tx_data,
  input  logic [7:0]            status_in,
  output logic [8*NUM_REGS-1:0] regs_out,
  output logic                  wr_strobe,
  output logic [6:0]            wr_addr,
  output logic                  addr_err,
  output logic [7:0]            frame_cnt,
  output logic                  busy
);

  localparam logic [6:0] LAST_REG = 7'(NUM_REGS - 1);

  state_e     state_q, state_d;
  logic       rw_q, rw_d;
  logic [6:0] addr_q, addr_d;
  logic       data_seen_q, data_seen_d;
  logic [7:0] tx_q, tx_d;
  logic       wr_strobe_q, wr_strobe_d;
  logic [6:0] wr_addr_q, wr_addr_d;
  logic       addr_err_q, addr_err_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;

  logic       bank_we;
  logic [6:0] raddr;
  logic [6:0] addr_next;
  logic [7:0] bank_rdata;
  logic [7:0] read_byte;
  logic       read_bad;

  function automatic logic is_reg(input logic [6:0] a);
    return (32'(a) < 32'(NUM_REGS));
  endfunction

  spi_reg_bank #(.NUM_REGS(NUM_REGS)) u_bank (
    .clk     (clk),
    .rst     (rst),
    .we_i    (bank_we),
    .waddr_i (addr_q),
    .wdata_i (rx_data),
    .raddr_i (raddr),
    .rdata_o (bank_rdata),
    .regs_o  (regs_out)
  );

  // Read address: the command's own address in CMD, the post-increment one in DATA.
  always_comb begin
    addr_next = addr_advance(addr_q, LAST_REG, STATUS_ADDR);
    raddr     = (state_q == CMD) ? rx_data[ADDR_MSB:0] : addr_next;
  end

  // Byte presented for a read of raddr, flagging illegal addresses.
  always_comb begin
    read_byte = BAD_BYTE;
    read_bad  = 1'b1;
    if (is_reg(raddr)) begin
      read_byte = bank_rdata;
      read_bad  = 1'b0;
    end else if (raddr == STATUS_ADDR) begin
      read_byte = status_in;
      read_bad  = 1'b0;
    end
  end

  // Frame sequencing: next state, address counter, tx preload, writes, counters.
  always_comb begin
    state_d     = state_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    data_seen_d = data_seen_q;
    tx_d        = tx_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    addr_err_d  = addr_err_q;
    frame_cnt_d = frame_cnt_q;
    bank_we     = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 8'h00;
        if (!ss) begin
          state_d     = CMD;
          data_seen_d = 1'b0;
        end
      end
      CMD: begin
        if (ss) begin
          // Command-only or empty frame: dropped without counting.
          state_d = IDLE;
          tx_d    = 8'h00;
        end else if (rx_done) begin
          rw_d    = rx_data[RW_BIT];
          addr_d  = rx_data[ADDR_MSB:0];
          state_d = DATA;
          if (rx_data[RW_BIT]) begin
            tx_d = 8'h00;
          end else begin
            tx_d = read_byte;
            if (read_bad) addr_err_d = 1'b1;
          end
        end
      end
      DATA: begin
        if (ss) begin
          // ss wins over a coincident rx_done, so that byte is lost.
          state_d = IDLE;
          tx_d    = 8'h00;
          if (data_seen_q) frame_cnt_d = frame_cnt_q + 8'd1;
        end else if (rx_done) begin
          data_seen_d = 1'b1;
          addr_d      = addr_next;
          if (rw_q) begin
            if (is_reg(addr_q)) begin
              bank_we     = 1'b1;
              wr_strobe_d = 1'b1;
              wr_addr_d   = addr_q;
            end else begin
              addr_err_d = 1'b1;
            end
          end else begin
            tx_d = read_byte;
            if (read_bad) addr_err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 8'h00;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      rw_q        <= 1'b0;
      addr_q      <= 7'd0;
      data_seen_q <= 1'b0;
      tx_q        <= 8'h00;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 7'd0;
      addr_err_q  <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      data_seen_q <= data_seen_d;
      tx_q        <= tx_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      addr_err_q  <= addr_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign tx_data   = tx_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign addr_err  = addr_err_q;
  assign frame_cnt = frame_cnt_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Scoreboard bench for spi_reg_ctrl: the driver pushes the expected
// post-byte / post-frame snapshot from a frame-level model; a monitor pops
// and compares whenever the DUT reacts to a byte or drops busy.
module tb_spi_reg_ctrl;

  localparam int M_IDLE = 0;
  localparam int M_CMD  = 1;
  localparam int M_DATA = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        ss;
  logic        rx_done;
  logic [7:0]  rx_data;
  logic [7:0]  tx_data;
  logic [7:0]  status_in;
  logic [31:0] regs_out;
  logic        wr_strobe;
  logic [6:0]  wr_addr;
  logic        addr_err;
  logic [7:0]  frame_cnt;
  logic        busy;

  spi_reg_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .ss        (ss),
    .rx_done   (rx_done),
    .rx_data   (rx_data),
    .tx_data   (tx_data),
    .status_in (status_in),
    .regs_out  (regs_out),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .addr_err  (addr_err),
    .frame_cnt (frame_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  tx;
    logic        strobe;
    logic [6:0]  waddr;
    logic        err;
    logic [7:0]  fcnt;
    logic [31:0] regs;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model state
  logic [7:0] m_regs[4];
  logic [7:0] m_tx;
  logic [6:0] m_waddr;
  logic       m_err;
  logic [7:0] m_fcnt;
  int         m_state;
  logic       m_rw;
  logic [6:0] m_addr;
  int         m_nd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic logic [31:0] m_pack();
    return {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    m_tx = 8'h00; m_waddr = 7'd0; m_err = 1'b0; m_fcnt = 8'd0;
    m_state = M_IDLE; m_rw = 1'b0; m_addr = 7'd0; m_nd = 0;
  endtask

  task automatic push(input logic strobe);
    exp_t e;
    e.tx = m_tx; e.strobe = strobe; e.waddr = m_waddr;
    e.err = m_err; e.fcnt = m_fcnt; e.regs = m_pack();
    exp_q.push_back(e);
  endtask

  task automatic m_read(input logic [6:0] a, output logic [7:0] v);
    if (a < 7'd4) v = m_regs[a[1:0]];
    else if (a == 7'h7F) v = status_in;
    else begin v = 8'hEE; m_err = 1'b1; end
  endtask

  task automatic m_byte(input logic [7:0] b, output logic strobe);
    strobe = 1'b0;
    if (m_state == M_CMD) begin
      m_rw = b[7]; m_addr = b[6:0]; m_nd = 0; m_state = M_DATA;
      if (m_rw) m_tx = 8'h00;
      else m_read(m_addr, m_tx);
    end else if (m_state == M_DATA) begin
      if (m_rw) begin
        if (m_addr < 7'd4) begin
          m_regs[m_addr[1:0]] = b; strobe = 1'b1; m_waddr = m_addr;
        end else begin
          m_err = 1'b1;
        end
      end
      m_nd++;
      if (m_addr != 7'h7F) m_addr = (m_addr == 7'd3) ? 7'd0 : m_addr + 7'd1;
      if (!m_rw) m_read(m_addr, m_tx);
    end
  endtask

  task automatic m_frame_end();
    if (m_state == M_DATA && m_nd > 0) m_fcnt = m_fcnt + 8'd1;
    m_state = M_IDLE;
    m_tx = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic begin_frame();
    ss = 1'b0;
    m_state = M_CMD;
    idle(2);
  endtask

  task automatic end_frame();
    m_frame_end();
    push(1'b0);
    ss = 1'b1;
    idle(3);
  endtask

  // One byte; with_ss raises ss in the same cycle as rx_done.
  task automatic send_byte(input logic [7:0] b, input logic with_ss);
    logic st;
    if (with_ss) begin
      if (m_state != M_IDLE) begin
        m_frame_end();
        push(1'b0);   // byte event
        push(1'b0);   // busy-fall event, same edge
      end else begin
        push(1'b0);
      end
      ss = 1'b1;
    end else begin
      m_byte(b, st);
      push(st);
    end
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    idle(3);
  endtask

  task automatic check_item(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_unexpected: got output event, expected none", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_tx_data"},   32'(tx_data),   32'(e.tx));
      chk({tag, "_wr_strobe"}, 32'(wr_strobe), 32'(e.strobe));
      chk({tag, "_wr_addr"},   32'(wr_addr),   32'(e.waddr));
      chk({tag, "_addr_err"},  32'(addr_err),  32'(e.err));
      chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(e.fcnt));
      chk({tag, "_regs_out"},  regs_out,       e.regs);
    end
  endtask

  // Monitor: a byte accepted on the previous edge, or busy dropping.
  logic rx_seen   = 1'b0;
  logic busy_prev = 1'b0;

  always @(posedge clk) rx_seen <= rx_done && rst;

  always @(negedge clk) begin
    if (rx_seen) check_item("byte");
    if (busy_prev && !busy) check_item("frame");
    busy_prev <= busy;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  task automatic check_reset_state(input string tag);
    chk({tag, "_tx_data"},   32'(tx_data),   32'h0);
    chk({tag, "_regs_out"},  regs_out,       32'h0);
    chk({tag, "_wr_strobe"}, 32'(wr_strobe), 32'h0);
    chk({tag, "_wr_addr"},   32'(wr_addr),   32'h0);
    chk({tag, "_addr_err"},  32'(addr_err),  32'h0);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'h0);
    chk({tag, "_busy"},      32'(busy),      32'h0);
  endtask

  initial begin
    logic [7:0] cmd;
    logic [6:0] a;
    int         sel;
    int         nd;
    rst = 1'b0; ss = 1'b1; rx_done = 1'b0; rx_data = 8'h00; status_in = 8'h00;
    m_reset();
    idle(3);
    check_reset_state("reset");
    rst = 1'b1;
    idle(2);

    // Single write to register 1
    begin_frame();
    send_byte(8'h81, 1'b0);
    send_byte(8'h5A, 1'b0);
    end_frame();
    chk("wr1_reg1", 32'(regs_out[15:8]), 32'h5A);
    chk("wr1_frame_cnt", 32'(frame_cnt), 32'd1);

    // Preload 11,22,33,44 then read burst from 3 with wrap
    begin_frame();
    send_byte(8'h80, 1'b0);
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0); send_byte(8'h44, 1'b0);
    end_frame();
    begin_frame();
    send_byte(8'h03, 1'b0);
    chk("rd_burst_first", 32'(tx_data), 32'h44);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b0);
    end_frame();

    // Illegal write, then status read
    begin_frame();
    send_byte(8'h90, 1'b0);
    send_byte(8'hAA, 1'b0);
    end_frame();
    chk("illegal_err", 32'(addr_err), 32'd1);
    status_in = 8'hC3;
    begin_frame();
    send_byte(8'h7F, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0);
    chk("status_tx", 32'(tx_data), 32'hC3);
    end_frame();

    // Abort after command byte; abort with ss coincident with a data byte
    begin_frame();
    send_byte(8'h82, 1'b0);
    end_frame();
    begin_frame();
    send_byte(8'h81, 1'b0);
    send_byte(8'hF0, 1'b1);
    chk("coincident_reg1", 32'(regs_out[15:8]), 32'h22);
    idle(2);

    // Reset mid-frame
    begin_frame();
    send_byte(8'h80, 1'b0);
    rst = 1'b0; ss = 1'b1;
    m_reset();
    push(1'b0);
    @(negedge clk);
    rst = 1'b1;
    check_reset_state("midreset");
    idle(2);
    begin_frame();
    send_byte(8'h82, 1'b0);
    send_byte(8'h77, 1'b0);
    end_frame();

    // Randomized frames
    for (int f = 0; f < 400; f++) begin
      status_in = 8'($urandom);
      if ($urandom_range(0, 15) == 0) send_byte(8'($urandom), 1'b0);
      begin_frame();
      if ($urandom_range(0, 9) == 0) begin
        end_frame();
        continue;
      end
      sel = $urandom_range(0, 7);
      if (sel <= 4) a = 7'($urandom_range(0, 3));
      else if (sel == 5) a = 7'h7F;
      else a = 7'($urandom);
      cmd = {1'($urandom), a};
      send_byte(cmd, 1'b0);
      nd = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
      for (int i = 0; i < nd; i++) send_byte(8'($urandom), 1'b0);
      if ($urandom_range(0, 7) == 0) begin
        send_byte(8'($urandom), 1'b1);
        idle(2);
      end else begin
        end_frame();
      end
    end

    idle(5);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
- Command controller that sequences the SPI slave byte datapath into a small register-access protocol.
- Decodes the first byte of each frame as a command (read/write plus address) and treats later bytes as data, with address auto-increment across bursts.
- Writes received data into a local register bank and preloads the SPI transmit byte for reads.
- Sits between the SPI slave (byte done pulse, received byte, byte to send) and the board-level logic (displays, LEDs, status).

Parameters:
- NUM_REGS, 4, number of writable 8-bit registers; legal addresses are 0..NUM_REGS-1.
- STATUS_ADDR, 7'h7F, read-only address that returns status_in.
- BAD_BYTE, 8'hEE, byte returned when reading an illegal address.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset; synchronous, active-low.
- ss  in  1  SPI slave select, active-low, already synchronised to clk.
- rx_done  in  1  one-cycle pulse from the SPI slave when a byte is complete.
- rx_data  in  8  received byte; valid when rx_done=1.
- tx_data  out  8  byte the SPI slave shifts out during the next byte slot.
- status_in  in  8  external status byte, readable at STATUS_ADDR.
- regs_out  out  8*NUM_REGS  register bank; register k occupies bits [8k+7:8k].
- wr_strobe  out  1  one-cycle pulse when a register is written.
- wr_addr  out  7  address of the last write; valid with wr_strobe.
- addr_err  out  1  sticky flag: an illegal address was accessed.
- frame_cnt  out  8  count of completed frames; wraps 255 -> 0.
- busy  out  1  high while a frame is in progress (state other than IDLE).

Behaviour:
- Reset (rst=0 at a clk edge), values:
  - state = IDLE
  - all regs_out = 0
  - tx_data = 8'h00
  - wr_strobe = 0, wr_addr = 0
  - addr_err = 0
  - frame_cnt = 0
- Reset overrides every other input in the same cycle. A reset mid-frame abandons the frame with no write.
- States: IDLE, CMD, DATA.
- IDLE: tx_data = 8'h00. When ss=0, go to CMD on the next cycle.
- CMD, on rx_done:
  - Latch rw = rx_data[7] (1 = write) and addr = rx_data[6:0]. Go to DATA.
  - If rw=0, tx_data is updated in the same clock edge (1-cycle latency from rx_done) with:
    - regs_out[addr] if addr < NUM_REGS;
    - status_in if addr == STATUS_ADDR;
    - BAD_BYTE otherwise, and addr_err is set to 1.
  - If rw=1, tx_data = 8'h00.
- DATA, on rx_done (each byte):
  - Write, addr < NUM_REGS: register[addr] = rx_data; wr_strobe = 1 for one cycle; wr_addr = addr.
  - Write, illegal address or STATUS_ADDR: data is dropped, no strobe, addr_err is set.
  - Read: the received byte is ignored.
  - After the byte, addr increments; NUM_REGS-1 wraps to 0.
  - STATUS_ADDR does not increment: repeated bytes keep returning status.
  - For reads, tx_data is reloaded from the new addr, with the same rule as CMD, in the same edge.
- A frame is any bytes between ss falling and ss rising. A frame counts as complete if at least a command byte plus one data byte were transferred; frame_cnt increments by 1 on the ss rise.
- ss=1 seen in CMD or DATA:
  - Return to IDLE next cycle.
  - A command-only frame is discarded: no write, no count.
- rx_done and ss=1 in the same cycle: ss wins. The byte is discarded and no write happens.
- rx_done while in IDLE (spurious) is ignored.
- tx_data must settle within one clk of rx_done. The SPI slave samples din at the start of the next byte, at least 8 SPI clocks later.
- addr_err is cleared only by reset.
- wr_strobe is never high for two consecutive cycles unless rx_done was.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=2'd0, CMD=2'd1, DATA=2'd2);
  - command bit positions (RW_BIT=7, ADDR_MSB=6);
  - STATUS_ADDR and BAD_BYTE defaults.
- One natural sub-module: spi_reg_bank, the NUM_REGS x 8 register array with write port and combinational read mux. spi_reg_ctrl keeps the FSM, address counter, tx_data and frame counter.

Test Plan:
- Write single: rst=0 then 1, ss=0, bytes 8'h81, 8'h5A, ss=1 -> regs_out[15:8] = 8'h5A; one wr_strobe with wr_addr=1; frame_cnt=1; addr_err=0.
- Read burst: regs {0:11, 1:22, 2:33, 3:44}; ss=0, bytes 8'h03, xx, xx, xx -> tx_data after each rx_done is 44, 11, 22, 33 (wrap from 3 to 0); no writes.
- Illegal address and status:
  - write 8'h90, 8'hAA -> no strobe, addr_err=1, regs unchanged;
  - read 8'h7F with status_in=8'hC3 -> tx_data=8'hC3 for each following byte.
- ss abort: ss=0, byte 8'h82, ss=1 before the data byte -> no write, frame_cnt unchanged, back to IDLE with tx_data=00.
- Simultaneous rx_done with ss=1 during a write data byte -> no strobe, register unchanged.
- Reset mid-frame, after byte 8'h80: assert rst=0 for 1 cycle -> all outputs at reset values; the next frame behaves normally.
